// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states,
// instruction fields, ALU codes and datapath mux selects.
package mc_pkg;

  localparam int ALU_W = 3;
  localparam int ST_W  = 4;

  typedef enum logic [ST_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;
  localparam logic [ALU_W-1:0] ALU_NOR = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU control decode: fixed add/sub, R-type funct, or
// I-type opcode selection; flags unknown funct codes.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [5:0]       opcode,
  output logic [ALU_W-1:0] alu_control,
  output logic             funct_valid
);

  logic [ALU_W-1:0] fn_ctrl;
  logic [ALU_W-1:0] imm_ctrl;

  always_comb begin
    funct_valid = 1'b1;
    fn_ctrl     = ALU_ADD;
    case (funct)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_NOR:  fn_ctrl = ALU_NOR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    imm_ctrl = ALU_ADD;
    case (opcode)
      OP_ANDI: imm_ctrl = ALU_AND;
      OP_ORI:  imm_ctrl = ALU_OR;
      OP_SLTI: imm_ctrl = ALU_SLT;
      default: imm_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = fn_ctrl;
      default:     alu_control = imm_ctrl;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences the shared ALU through fetch, decode,
// execute, memory and writeback, stalling on the memory-ready handshake.
module mc_controller
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_srcA,
  output logic [1:0]       alu_srcB,
  output logic             imm_zext,
  output logic [1:0]       pc_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal_op
);

  state_t           state, next;
  logic [1:0]       alu_op;
  logic             alu_en;
  logic [ALU_W-1:0] dec_ctrl;
  logic             funct_valid;
  logic             is_logic_imm;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .opcode      (opcode),
    .alu_control (dec_ctrl),
    .funct_valid (funct_valid)
  );

  assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
  // States that do not use the ALU present 000 on alu_control.
  assign alu_control  = alu_en ? dec_ctrl : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_srcA   = 1'b0;
    alu_srcB   = SRCB_B;
    imm_zext   = 1'b0;
    pc_src     = PC_ALU;
    illegal_op = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_en     = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        alu_srcB = SRCB_FOUR;
        alu_en   = 1'b1;
        ir_write = mem_ready;
        pc_en    = mem_ready;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        alu_srcB = SRCB_IMM_SH;
        alu_en   = 1'b1;
        case (opcode)
          OP_LW, OP_SW:                     next = MEMADR;
          OP_RTYPE:                         next = EXEC;
          OP_BEQ, OP_BNE:                   next = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next = IEXEC;
          OP_J:                             next = JUMP;
          default: begin
            illegal_op = 1'b1;
            next       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_IMM;
        alu_en   = 1'b1;
        next     = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next       = FETCH;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next = FETCH;
      end
      EXEC: begin
        alu_srcA = 1'b1;
        alu_op   = ALUOP_FUNCT;
        alu_en   = 1'b1;
        next     = ALUWB;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = funct_valid;
        illegal_op = ~funct_valid;
        next       = FETCH;
      end
      BRANCH: begin
        alu_srcA = 1'b1;
        alu_op   = ALUOP_SUB;
        alu_en   = 1'b1;
        pc_src   = PC_ALUOUT;
        pc_en    = (opcode == OP_BEQ) ? zero : ~zero;
        next     = FETCH;
      end
      IEXEC: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_IMM;
        alu_op   = ALUOP_IMM;
        alu_en   = 1'b1;
        imm_zext = is_logic_imm;
        next     = IWB;
      end
      IWB: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_IMM;
        alu_en    = 1'b1;
        imm_zext  = is_logic_imm;
        next      = FETCH;
      end
      JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
        next   = FETCH;
      end
      default: next = FETCH;
    endcase
    // Reset aborts any in-flight access in the same cycle.
    if (rst) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_srcA   = 1'b0;
      alu_srcB   = SRCB_B;
      imm_zext   = 1'b0;
      pc_src     = PC_ALU;
      illegal_op = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_en     = 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scenario bench for mc_controller: per-cycle expected output vectors are
// queued as stimulus is applied and compared at the falling edge.
module tb_mc_controller;

  logic       clk, rst, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_en, ir_write, mem_req, mem_write, iord, reg_write;
  logic       reg_dst, mem_to_reg, alu_srcA, imm_zext, illegal_op;
  logic [1:0] alu_srcB, pc_src;
  logic [2:0] alu_control;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [17:0] e;
  } row_t;

  logic [17:0] sb [$];
  logic [17:0] act;
  logic [17:0] RST, F0, F1, DEC, MADR;
  int          vectors    = 0;
  int          miscompares = 0;

  mc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .imm_zext(imm_zext),
    .pc_src(pc_src), .alu_control(alu_control), .illegal_op(illegal_op)
  );

  assign act = {pc_en, ir_write, mem_req, mem_write, iord, reg_write, reg_dst,
                mem_to_reg, alu_srcA, alu_srcB, imm_zext, pc_src, alu_control,
                illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ov(
    input logic pe, iw, mq, mw, io, rw, rd, m2r, sa,
    input logic [1:0] srcb, input logic zx, input logic [1:0] ps,
    input logic [2:0] alu, input logic il);
    return {pe, iw, mq, mw, io, rw, rd, m2r, sa, srcb, zx, ps, alu, il};
  endfunction

  function automatic row_t mk(input logic r, mr, z, input logic [5:0] op,
                              input logic [5:0] fn, input logic [17:0] e);
    return '{r, mr, z, op, fn, e};
  endfunction

  task automatic test_reset();
    row_t r [3];
    logic [17:0] exp;
    for (int i = 0; i < 3; i++) r[i] = mk(1, 1, 1, 6'b100011, 6'b100000, RST);
    for (int i = 0; i < 3; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      sb.push_back(r[i].e);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL reset row%0d: got %b want %b", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    row_t r [9];
    logic [17:0] exp;
    r[0] = mk(0, 0, 0, 6'b100011, 0, F0);
    r[1] = mk(0, 0, 0, 6'b100011, 0, F0);
    r[2] = mk(0, 1, 0, 6'b100011, 0, F1);
    r[3] = mk(0, 0, 0, 6'b100011, 0, DEC);
    r[4] = mk(0, 0, 0, 6'b100011, 0, MADR);
    r[5] = mk(0, 0, 0, 6'b100011, 0, ov(0,0,1,0,1,0,0,0,0,2'b00,0,2'b00,3'b000,0));
    r[6] = mk(0, 1, 0, 6'b100011, 0, ov(0,0,1,0,1,0,0,0,0,2'b00,0,2'b00,3'b000,0));
    r[7] = mk(0, 0, 0, 6'b100011, 0, ov(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,3'b000,0));
    r[8] = mk(0, 0, 0, 6'b100011, 0, F0);
    for (int i = 0; i < 9; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      sb.push_back(r[i].e);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL lw row%0d: got %b want %b", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_sub();
    row_t r [5];
    logic [17:0] exp;
    r[0] = mk(0, 1, 0, 6'b000000, 6'b100010, F1);
    r[1] = mk(0, 0, 0, 6'b000000, 6'b100010, DEC);
    r[2] = mk(0, 0, 0, 6'b000000, 6'b100010, ov(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b110,0));
    r[3] = mk(0, 0, 0, 6'b000000, 6'b100010, ov(0,0,0,0,0,1,1,0,0,2'b00,0,2'b00,3'b000,0));
    r[4] = mk(0, 0, 0, 6'b000000, 6'b100010, F0);
    for (int i = 0; i < 5; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      sb.push_back(r[i].e);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL rtype_sub row%0d: got %b want %b", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3] = '{6'b000100, 6'b000100, 6'b000101};
    logic       zs  [3] = '{1'b1, 1'b0, 1'b0};
    logic       pes [3] = '{1'b1, 1'b0, 1'b1};
    row_t r [3];
    logic [17:0] exp;
    for (int k = 0; k < 3; k++) begin
      r[0] = mk(0, 1, zs[k], ops[k], 0, F1);
      r[1] = mk(0, 0, zs[k], ops[k], 0, DEC);
      r[2] = mk(0, 0, zs[k], ops[k], 0,
                ov(pes[k],0,0,0,0,0,0,0,1,2'b00,0,2'b01,3'b110,0));
      for (int i = 0; i < 3; i++) begin
        rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
        opcode = r[i].op; funct = r[i].fn;
        sb.push_back(r[i].e);
        @(negedge clk);
        exp = sb.pop_front(); vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL branch%0d row%0d: got %b want %b", k, i, act, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_ori();
    row_t r [5];
    logic [17:0] exp;
    r[0] = mk(0, 1, 0, 6'b001101, 0, F1);
    r[1] = mk(0, 0, 0, 6'b001101, 0, DEC);
    r[2] = mk(0, 0, 0, 6'b001101, 0, ov(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b001,0));
    r[3] = mk(0, 0, 0, 6'b001101, 0, ov(0,0,0,0,0,1,0,0,0,2'b00,1,2'b00,3'b001,0));
    r[4] = mk(0, 0, 0, 6'b001101, 0, F0);
    for (int i = 0; i < 5; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      sb.push_back(r[i].e);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL ori row%0d: got %b want %b", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    row_t r [8];
    logic [17:0] exp, m;
    r[0] = mk(0, 1, 0, 6'b111111, 0, F1);
    r[1] = mk(0, 0, 0, 6'b111111, 0, ov(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b010,1));
    r[2] = mk(0, 0, 0, 6'b111111, 0, F0);
    r[3] = mk(0, 1, 0, 6'b000000, 6'b000111, F1);
    r[4] = mk(0, 0, 0, 6'b000000, 6'b000111, DEC);
    r[5] = mk(0, 0, 0, 6'b000000, 6'b000111, ov(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b000,0));
    r[6] = mk(0, 0, 0, 6'b000000, 6'b000111, ov(0,0,0,0,0,0,1,0,0,2'b00,0,2'b00,3'b000,1));
    r[7] = mk(0, 0, 0, 6'b000000, 6'b000111, F0);
    for (int i = 0; i < 8; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      // ALU code for an unknown funct is don't-care in EXEC.
      m = (i == 5) ? 18'h3FFF1 : 18'h3FFFF;
      sb.push_back(r[i].e & m);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if ((act & m) !== exp) begin
        miscompares++;
        $display("FAIL illegal row%0d: got %b want %b", i, act & m, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t r [11];
    logic [17:0] exp;
    r[0]  = mk(0, 1, 0, 6'b000010, 0, F1);
    r[1]  = mk(0, 0, 0, 6'b000010, 0, DEC);
    r[2]  = mk(0, 0, 0, 6'b000010, 0, ov(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,3'b000,0));
    r[3]  = mk(0, 1, 0, 6'b001010, 0, F1);
    r[4]  = mk(0, 0, 0, 6'b001010, 0, DEC);
    r[5]  = mk(0, 0, 0, 6'b001010, 0, ov(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b111,0));
    r[6]  = mk(0, 0, 0, 6'b001010, 0, ov(0,0,0,0,0,1,0,0,0,2'b00,0,2'b00,3'b111,0));
    r[7]  = mk(0, 1, 0, 6'b000000, 6'b100111, F1);
    r[8]  = mk(0, 0, 0, 6'b000000, 6'b100111, DEC);
    r[9]  = mk(0, 0, 0, 6'b000000, 6'b100111, ov(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b101,0));
    r[10] = mk(0, 0, 0, 6'b000000, 6'b100111, ov(0,0,0,0,0,1,1,0,0,2'b00,0,2'b00,3'b000,0));
    for (int i = 0; i < 11; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      sb.push_back(r[i].e);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL back_to_back row%0d: got %b want %b", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_store();
    row_t r [7];
    logic [17:0] exp;
    r[0] = mk(0, 1, 0, 6'b101011, 0, F1);
    r[1] = mk(0, 0, 0, 6'b101011, 0, DEC);
    r[2] = mk(0, 0, 0, 6'b101011, 0, MADR);
    r[3] = mk(0, 0, 0, 6'b101011, 0, ov(0,0,1,1,1,0,0,0,0,2'b00,0,2'b00,3'b000,0));
    r[4] = mk(0, 0, 0, 6'b101011, 0, ov(0,0,1,1,1,0,0,0,0,2'b00,0,2'b00,3'b000,0));
    r[5] = mk(1, 0, 0, 6'b101011, 0, RST);
    r[6] = mk(0, 0, 0, 6'b101011, 0, F0);
    for (int i = 0; i < 7; i++) begin
      rst = r[i].rst; mem_ready = r[i].mr; zero = r[i].z;
      opcode = r[i].op; funct = r[i].fn;
      sb.push_back(r[i].e);
      @(negedge clk);
      exp = sb.pop_front(); vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_store row%0d: got %b want %b", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    RST  = ov(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,3'b010,0);
    F0   = ov(0,0,1,0,0,0,0,0,0,2'b01,0,2'b00,3'b010,0);
    F1   = ov(1,1,1,0,0,0,0,0,0,2'b01,0,2'b00,3'b010,0);
    DEC  = ov(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b010,0);
    MADR = ov(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b010,0);
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_rtype_sub();
    test_branch();
    test_ori();
    test_illegal();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
